video_timing_generator: RTL
===========================

# video_timing_generator

Parametrised raster timing generator for the Spectrum core video path. It counts pixels and lines, produces registered hsync, vsync, csync and blanking, gates RGB, and generates the retrace and raster interrupts to the CPU. Every horizontal and vertical threshold is a runtime input. Timing changes take effect only at a frame boundary, so one bench-verified block covers 48K, 128K, Pentagon and NTSC, plus custom modes.

## Interface
Parameters:
- HW, 9, horizontal counter width (bits)
- VW, 9, vertical counter width (bits)
- CDW, 3, colour depth per channel

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clken  in  1  pixel enable; state advances only when 1
- h_total, h_blank_start, h_blank_end, h_sync_start, h_sync_end, int_h_start, int_h_end  in  HW  horizontal config (inclusive bounds)
- v_total, v_blank_start, v_blank_end, v_sync_start, v_sync_end, int_v_line  in  VW  vertical config
- vretraceint_disable  in  1  suppress retrace interrupt
- rasterint_enable  in  1  enable raster interrupt
- raster_line  in  VW  raster interrupt target line
- ri, gi, bi  in  CDW  pixel colour
- hcnt  out  HW  current pixel counter
- vcnt  out  VW  current line counter
- ro, go, bo  out  CDW  blanked colour, registered
- hsync, vsync, csync  out  1  active-low syncs, registered; csync = hsync AND vsync
- hblank, vblank  out  1  active-high, registered
- int_n  out  1  active-low combined interrupt, registered
- raster_int_in_progress  out  1  raster interrupt term active, registered
- frame_cnt  out  8  frame counter, wraps 255->0

## Operation
- Active set: internal shadow copies of all config inputs except raster_line, rasterint_enable and vretraceint_disable. Those three are used live.
- Loading the active set:
  - on rst;
  - on the frame wrap, i.e. clken=1 with hc==h_total and vc==v_total.
  - Mid-frame config changes are ignored until the next wrap.
- Counters:
  - hc increments each clken.
  - When hc==h_total, hc goes to 0 and vc increments.
  - When vc==v_total at the same time, vc goes to 0 and frame_cnt increments.
- Range test for each start/end pair:
  - start<=end: in range when start<=c<=end;
  - start>end: in range when c>=start OR c<=end (wrap-around);
  - start==end: a single position.
- Decodes:
  - hblank and vblank from their ranges;
  - hsync=0 inside the h_sync range;
  - vsync=0 inside the v_sync range.
- Colour: ro/go/bo = 0 when hblank OR vblank, otherwise ri/gi/bi.
- Retrace term: active when vretraceint_disable=0, vc==int_v_line, and hc is in the int_h range.
- Raster term: active when rasterint_enable=1, hc is in [256,319] (clamped to h_total), and vc is one line before raster_line.
  - For raster_line==0, "one line before" is v_total.
  - Widths are VW, so raster_line-1 never underflows in the comparison.
- int_n = NOT(retrace term OR raster term).
- raster_int_in_progress = raster term.
- Out-of-range config (e.g. sync start > h_total) is not an error; the decode simply never or always matches.

## Timing
- Reset values:
  - hc=0, vc=0, frame_cnt=0;
  - hsync=vsync=csync=1, hblank=vblank=0, int_n=1, raster_int_in_progress=0;
  - ro=go=bo=0.
- hcnt/vcnt are the counter registers themselves, with zero latency.
- All other outputs are registered with one clken-cycle latency against the counters. An output updated at clken edge n reflects the hc/vc values present before edge n, together with ri/gi/bi sampled at edge n.
- clken=0: counters, shadows and all registered outputs hold.
- rst has priority over clken and takes effect on the next clk edge even when clken=0. Reset mid-frame restarts at (0,0) with the new config.
- The frame wrap and the shadow load happen on the same edge. The first pixel of the new frame is decoded with the new set.

## Test plan
- Reset 48K: apply 48K config (h_total 447, v_total 311, hsync 344–375, vsync 248–251, int_v_line 248, int_h 4–67), rst 1 cycle, clken=1 -> hsync is low for exactly 32 clken cycles per line, first falling edge one cycle after hcnt=344; int_n is low for 64 cycles on line 248; the frame is 448×312 clken cycles; frame_cnt increments.
- Mid-frame switch: at vcnt=100, change to 128K (h_total 455, v_total 310) -> the current frame keeps a 448-pixel line length; the next frame uses 456 pixels × 311 lines.
- Wrap-around range: h_sync_start 440, h_sync_end 7 with h_total 447 -> hsync is low for hc 440..447 and 0..7 (16 cycles contiguous across the line wrap).
- Raster interrupt: rasterint_enable=1, raster_line 0, v_total 311 -> int_n and raster_int_in_progress are active for hc 256..319 on line 311 only. With raster_line 100, the same window occurs on line 99.
- clken gating: toggle clken 1-of-4 -> outputs change only on enabled edges. Pulse rst with clken=0 -> all reset values appear on the next clk edge.
- Blanking: ri/gi/bi=7 constant, vblank 248–255 -> ro=0 for lines 248..255 and during the hblank range, ro=7 elsewhere, with one cycle of latency.

Source files
------------

// File: rtl/video_timing_generator.sv
// Raster timing generator: pixel/line counters, registered sync/blank/colour decode,
// and retrace/raster interrupts. Geometry is latched into an active set at reset and frame wrap.
module video_timing_generator #(
  parameter int HW  = 9,
  parameter int VW  = 9,
  parameter int CDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clken,
  input  logic [HW-1:0]  h_total,
  input  logic [HW-1:0]  h_blank_start,
  input  logic [HW-1:0]  h_blank_end,
  input  logic [HW-1:0]  h_sync_start,
  input  logic [HW-1:0]  h_sync_end,
  input  logic [HW-1:0]  int_h_start,
  input  logic [HW-1:0]  int_h_end,
  input  logic [VW-1:0]  v_total,
  input  logic [VW-1:0]  v_blank_start,
  input  logic [VW-1:0]  v_blank_end,
  input  logic [VW-1:0]  v_sync_start,
  input  logic [VW-1:0]  v_sync_end,
  input  logic [VW-1:0]  int_v_line,
  input  logic           vretraceint_disable,
  input  logic           rasterint_enable,
  input  logic [VW-1:0]  raster_line,
  input  logic [CDW-1:0] ri,
  input  logic [CDW-1:0] gi,
  input  logic [CDW-1:0] bi,
  output logic [HW-1:0]  hcnt,
  output logic [VW-1:0]  vcnt,
  output logic [CDW-1:0] ro,
  output logic [CDW-1:0] go,
  output logic [CDW-1:0] bo,
  output logic           hsync,
  output logic           vsync,
  output logic           csync,
  output logic           hblank,
  output logic           vblank,
  output logic           int_n,
  output logic           raster_int_in_progress,
  output logic [7:0]     frame_cnt
);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;

  logic [HW-1:0] a_h_total, a_h_blank_start, a_h_blank_end, a_h_sync_start, a_h_sync_end;
  logic [HW-1:0] a_int_h_start, a_int_h_end;
  logic [VW-1:0] a_v_total, a_v_blank_start, a_v_blank_end, a_v_sync_start, a_v_sync_end;
  logic [VW-1:0] a_int_v_line;

  logic          line_end, wrap;
  logic          hb_d, vb_d, hs_d, vs_d, retrace_d, raster_d;
  logic [VW-1:0] raster_target;

  // start > end means the range wraps through the counter's end back to zero
  function automatic logic in_range(input logic [31:0] c, input logic [31:0] s,
                                    input logic [31:0] e);
    if (s <= e) return (c >= s) && (c <= e);
    return (c >= s) || (c <= e);
  endfunction

  assign hcnt     = hc;
  assign vcnt     = vc;
  assign line_end = (hc == a_h_total);
  assign wrap     = line_end && (vc == a_v_total);

  always_ff @(posedge clk) begin
    if (rst || (clken && wrap)) begin
      a_h_total       <= h_total;
      a_h_blank_start <= h_blank_start;
      a_h_blank_end   <= h_blank_end;
      a_h_sync_start  <= h_sync_start;
      a_h_sync_end    <= h_sync_end;
      a_int_h_start   <= int_h_start;
      a_int_h_end     <= int_h_end;
      a_v_total       <= v_total;
      a_v_blank_start <= v_blank_start;
      a_v_blank_end   <= v_blank_end;
      a_v_sync_start  <= v_sync_start;
      a_v_sync_end    <= v_sync_end;
      a_int_v_line    <= int_v_line;
    end
  end

  always_comb begin
    hb_d = in_range(32'(hc), 32'(a_h_blank_start), 32'(a_h_blank_end));
    vb_d = in_range(32'(vc), 32'(a_v_blank_start), 32'(a_v_blank_end));
    hs_d = !in_range(32'(hc), 32'(a_h_sync_start), 32'(a_h_sync_end));
    vs_d = !in_range(32'(vc), 32'(a_v_sync_start), 32'(a_v_sync_end));
    retrace_d = !vretraceint_disable && (vc == a_int_v_line) &&
                in_range(32'(hc), 32'(a_int_h_start), 32'(a_int_h_end));
    // raster interrupt fires on the line before the target, wrapping to v_total for line 0
    raster_target = (raster_line == '0) ? a_v_total : raster_line - VW'(1);
    raster_d = rasterint_enable && (vc == raster_target) &&
               (32'(hc) >= 32'd256) && (32'(hc) <= 32'd319) && (hc <= a_h_total);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc                     <= '0;
      vc                     <= '0;
      frame_cnt              <= '0;
      hsync                  <= 1'b1;
      vsync                  <= 1'b1;
      csync                  <= 1'b1;
      hblank                 <= 1'b0;
      vblank                 <= 1'b0;
      int_n                  <= 1'b1;
      raster_int_in_progress <= 1'b0;
      ro                     <= '0;
      go                     <= '0;
      bo                     <= '0;
    end else if (clken) begin
      hsync                  <= hs_d;
      vsync                  <= vs_d;
      csync                  <= hs_d & vs_d;
      hblank                 <= hb_d;
      vblank                 <= vb_d;
      int_n                  <= !(retrace_d || raster_d);
      raster_int_in_progress <= raster_d;
      ro                     <= (hb_d || vb_d) ? '0 : ri;
      go                     <= (hb_d || vb_d) ? '0 : gi;
      bo                     <= (hb_d || vb_d) ? '0 : bi;
      if (line_end) begin
        hc <= '0;
        if (wrap) begin
          vc        <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          vc <= vc + VW'(1);
        end
      end else begin
        hc <= hc + HW'(1);
      end
    end
  end

endmodule
